comparator_seq: RTL and testbench
=================================

// Module: comparator_seq
// PURPOSE
//  Sequencer that compares two WIDTH-bit operands with a single 4-bit cascadable
//  `comparator` instance, one nibble per clock, LSB nibble first.
//  Each nibble's g/e/l result is registered and fed back as the cascade input
//  for the next, more significant, nibble.
//  Start/done handshake; sits between the datapath and any unit that needs
//  wide magnitude compares without a full-width comparator.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of 4, >= 4 (elaboration-time check)
//  SIGNED  0   1 = two's-complement compare, 0 = unsigned
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      synchronous active-high reset
//  start  in   1      request a compare; sampled only when accepting (see below)
//  a      in   WIDTH  operand A; captured on the accepting edge
//  b      in   WIDTH  operand B; captured on the accepting edge
//  busy   out  1      high while state == RUN
//  done   out  1      single-cycle pulse; result valid
//  gt     out  1      A > B (registered, held until next accept or reset)
//  eq     out  1      A == B
//  lt     out  1      A < B
// BEHAVIOUR
//  - N = WIDTH/4 nibbles. States: IDLE, RUN, DONE.
//  - Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, gt=eq=lt=0,
//    cnt=0, operand regs cleared. Any in-flight compare is discarded.
//  - Accept: start=1 on an edge in IDLE or DONE.
//    - Latch a and b; cnt=0; cascade reg {g,e,l}=3'b010; state->RUN.
//    - start in RUN is ignored; operands are not re-sampled.
//  - RUN, each edge:
//    - Drive comparator a/b with nibble[cnt] of the latched operands and
//      g_in/e_in/l_in with the cascade reg.
//    - Register comparator {g_out,e_out,l_out} into the cascade reg; cnt++.
//    - Comparator contract: a>b -> g=1; a<b -> l=1; equal -> outputs copy cascade inputs.
//  - SIGNED=1: invert bit 3 of the MSB nibble (cnt==N-1) of both operands before
//    the comparator. Lower nibbles are unmodified.
//  - On the RUN edge with cnt==N-1:
//    - Copy comparator outputs to gt/eq/lt; state->DONE; done=1.
//    - Exactly one of gt/eq/lt is 1 whenever done=1.
//  - DONE lasts one cycle; next edge -> IDLE (done=0), or -> RUN if start=1
//    (back-to-back; gt/eq/lt keep the old result until the new done).
//  - Latency: done high during the cycle after the N-th edge following the
//    accepting edge. Throughput: one compare per N+1 cycles; N with
//    back-to-back start in DONE.
//  - WIDTH=4: RUN lasts one edge; done follows the accept by one edge.
//  - cnt width = max(1,$clog2(N)); cnt never exceeds N-1.
// TESTING
//  1. WIDTH=16, a=16'h1234, b=16'h1235, start 1 cycle.
//     -> busy for 4 cycles; done pulse; lt=1, gt=0, eq=0.
//  2. a=16'h8000, b=16'h0001: SIGNED=0 -> gt=1; SIGNED=1 -> lt=1.
//     a=16'hFFFF, b=16'hFFFE with SIGNED=1 -> gt=1.
//  3. a=b=16'hA5A5 -> eq=1.
//     Then a=16'h0F00, b=16'h0E00: MSB nibble equal, lower nibble decides -> gt=1.
//  4. start held high with changing a/b during RUN -> ignored; result matches the
//     operands captured at the accept.
//     Back-to-back start during DONE -> second done exactly 4 cycles after the first.
//  5. rst asserted at RUN cycle 2 -> next cycle busy=0, done=0, gt=eq=lt=0;
//     no done pulse follows.
//     Fresh start after reset completes normally.
//  6. Random WIDTH=16 and WIDTH=4 operands, both SIGNED values, >=1000 compares
//     -> gt/eq/lt match the reference model every time.

Source files
------------

// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - nibble-serial cascaded magnitude comparator sequencer

// 4-bit cascadable comparator: a strict inequality decides locally,
// an equal nibble passes the less significant verdict through.
module comparator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       g_in,
    input  logic       e_in,
    input  logic       l_in,
    output logic       g_out,
    output logic       e_out,
    output logic       l_out
);

    // Local magnitude decision, falling back to the cascade on a tie
    always_comb begin
        g_out = 1'b0;
        e_out = 1'b0;
        l_out = 1'b0;
        if (a > b) begin
            g_out = 1'b1;
        end else if (a < b) begin
            l_out = 1'b1;
        end else begin
            g_out = g_in;
            e_out = e_in;
            l_out = l_in;
        end
    end

endmodule

module comparator_seq #(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("comparator_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       cas_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    // Comparator feed. In DONE the comparator looks at the live inputs so a
    // back-to-back accept also consumes nibble 0 on the accepting edge,
    // which keeps the back-to-back throughput at one compare per N cycles.
    logic             from_done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]    sel_cnt;
    logic [2:0]       cas_in;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             sel_last;
    logic [2:0]       cmp_d;

    // Select the active nibble and apply the sign-bit flip on the top nibble
    always_comb begin
        from_done = (state_q == DONE);
        op_a      = from_done ? a : a_q;
        op_b      = from_done ? b : b_q;
        sel_cnt   = from_done ? '0 : cnt_q;
        cas_in    = from_done ? 3'b010 : cas_q;
        sel_last  = (sel_cnt == LAST);
        nib_a     = '0;
        nib_b     = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_cnt == CW'(i)) begin
                nib_a = op_a[4*i +: 4];
                nib_b = op_b[4*i +: 4];
            end
        end
        // Flipping the sign bit maps two's-complement order onto unsigned order
        if (SIGNED != 0 && sel_last) begin
            nib_a[3] = ~nib_a[3];
            nib_b[3] = ~nib_b[3];
        end
    end

    comparator u_cmp (
        .a     (nib_a),
        .b     (nib_b),
        .g_in  (cas_in[2]),
        .e_in  (cas_in[1]),
        .l_in  (cas_in[0]),
        .g_out (cmp_d[2]),
        .e_out (cmp_d[1]),
        .l_out (cmp_d[0])
    );

    // Sequencer FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            cas_q   <= 3'b010;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= '0;
                        cas_q   <= 3'b010;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN, DONE: begin
                    if (state_q == RUN || start) begin
                        if (state_q == DONE) begin
                            a_q <= a;
                            b_q <= b;
                        end
                        cas_q <= cmp_d;
                        if (sel_last) begin
                            gt_q    <= cmp_d[2];
                            eq_q    <= cmp_d[1];
                            lt_q    <= cmp_d[0];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= sel_cnt + CW'(1);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - scoreboard bench for comparator_seq, 16/4-bit, signed/unsigned
module tb_comparator_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  busy_v, done_v, gt_v, eq_v, lt_v;

    int checks = 0;
    int errors = 0;
    int lat_v[4];

    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] q2[$];
    logic [2:0] q3[$];

    always #5 clk = ~clk;

    // index 0: 16 unsigned, 1: 16 signed, 2: 4 unsigned, 3: 4 signed
    comparator_seq #(.WIDTH(16), .SIGNED(0)) u16u (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in), .b(b_in),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));
    comparator_seq #(.WIDTH(16), .SIGNED(1)) u16s (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in), .b(b_in),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));
    comparator_seq #(.WIDTH(4), .SIGNED(0)) u4u (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[3:0]), .b(b_in[3:0]),
        .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));
    comparator_seq #(.WIDTH(4), .SIGNED(1)) u4s (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a_in[3:0]), .b(b_in[3:0]),
        .busy(busy_v[3]), .done(done_v[3]), .gt(gt_v[3]), .eq(eq_v[3]), .lt(lt_v[3]));

    function automatic int dut_w(input int i);
        return (i < 2) ? 16 : 4;
    endfunction

    function automatic bit dut_s(input int i);
        return (i % 2) == 1;
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [15:0] av, input logic [15:0] bv,
                                           input int w, input bit sgn);
        longint x, y, m;
        m = (longint'(1) << w) - 1;
        x = longint'(av) & m;
        y = longint'(bv) & m;
        if (sgn) begin
            if (x[w-1]) x = x - (longint'(1) << w);
            if (y[w-1]) y = y - (longint'(1) << w);
        end
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    function automatic void push_exp(input int i, input logic [2:0] v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic int q_size(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [2:0] pop_exp(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        logic [2:0] got, ex;
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] === 1'b1) begin
                got = {gt_v[i], eq_v[i], lt_v[i]};
                checks++;
                if (q_size(i) == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done dut=%0d got gel=%b expected no done", i, got);
                end else begin
                    ex = pop_exp(i);
                    if (got !== ex) begin
                        errors++;
                        $display("FAIL sb_result dut=%0d got gel=%b expected gel=%b", i, got, ex);
                    end
                end
            end
        end
    end

    task automatic run_cmp(input logic [3:0] sel, input logic [15:0] av, input logic [15:0] bv);
        logic [3:0] seen;
        int n;
        @(posedge clk); #1;
        a_in    = av;
        b_in    = bv;
        start_v = sel;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                push_exp(i, ref_cmp(av, bv, dut_w(i), dut_s(i)));
                lat_v[i] = 0;
            end
        end
        @(posedge clk); #1;
        start_v = '0;
        seen = '0;
        n = 0;
        while (seen != sel && n < 40) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 4; i++) begin
                if (sel[i] && !seen[i] && done_v[i] === 1'b1) begin
                    seen[i]  = 1'b1;
                    lat_v[i] = n;
                end
            end
        end
        checks++;
        if (seen != sel) begin
            errors++;
            $display("FAIL run_timeout got seen=%b expected %b", seen, sel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_v = '0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_v !== 4'b0) begin errors++; $display("FAIL reset_busy got %b expected 0000", busy_v); end
        checks++; if (done_v !== 4'b0) begin errors++; $display("FAIL reset_done got %b expected 0000", done_v); end
        checks++; if (gt_v !== 4'b0) begin errors++; $display("FAIL reset_gt got %b expected 0000", gt_v); end
        checks++; if (eq_v !== 4'b0) begin errors++; $display("FAIL reset_eq got %b expected 0000", eq_v); end
        checks++; if (lt_v !== 4'b0) begin errors++; $display("FAIL reset_lt got %b expected 0000", lt_v); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        a_in = 16'h1234;
        b_in = 16'h1235;
        start_v = 4'b0001;
        push_exp(0, 3'b001);
        @(posedge clk); #1;
        start_v = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle=%0d got busy=%b done=%b expected busy=1 done=0", k, busy_v[0], done_v[0]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_done got busy=%b done=%b expected busy=0 done=1", busy_v[0], done_v[0]);
        end
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || {gt_v[0], eq_v[0], lt_v[0]} !== 3'b001) begin
            errors++;
            $display("FAIL basic_hold got done=%b gel=%b expected done=0 gel=001", done_v[0], {gt_v[0], eq_v[0], lt_v[0]});
        end
    endtask

    task automatic test_signed();
        run_cmp(4'b0011, 16'h8000, 16'h0001);
        checks++;
        if ({gt_v[0], eq_v[0], lt_v[0]} !== 3'b100 || {gt_v[1], eq_v[1], lt_v[1]} !== 3'b001) begin
            errors++;
            $display("FAIL signed_8000 got u=%b s=%b expected u=100 s=001",
                     {gt_v[0], eq_v[0], lt_v[0]}, {gt_v[1], eq_v[1], lt_v[1]});
        end
        run_cmp(4'b0010, 16'hFFFF, 16'hFFFE);
        checks++;
        if ({gt_v[1], eq_v[1], lt_v[1]} !== 3'b100) begin
            errors++;
            $display("FAIL signed_ffff got %b expected 100", {gt_v[1], eq_v[1], lt_v[1]});
        end
        checks++;
        if (lat_v[1] != 5) begin
            errors++;
            $display("FAIL latency16 got %0d expected 5", lat_v[1]);
        end
    endtask

    task automatic test_equal();
        run_cmp(4'b0011, 16'hA5A5, 16'hA5A5);
        checks++;
        if ({gt_v[0], eq_v[0], lt_v[0]} !== 3'b010) begin
            errors++;
            $display("FAIL equal got %b expected 010", {gt_v[0], eq_v[0], lt_v[0]});
        end
        run_cmp(4'b0001, 16'h0F00, 16'h0E00);
        checks++;
        if ({gt_v[0], eq_v[0], lt_v[0]} !== 3'b100) begin
            errors++;
            $display("FAIL low_nibble_decides got %b expected 100", {gt_v[0], eq_v[0], lt_v[0]});
        end
    endtask

    task automatic test_width4();
        run_cmp(4'b1100, 16'h0008, 16'h0001);
        checks++;
        if ({gt_v[2], eq_v[2], lt_v[2]} !== 3'b100 || {gt_v[3], eq_v[3], lt_v[3]} !== 3'b001) begin
            errors++;
            $display("FAIL width4 got u=%b s=%b expected u=100 s=001",
                     {gt_v[2], eq_v[2], lt_v[2]}, {gt_v[3], eq_v[3], lt_v[3]});
        end
        checks++;
        if (lat_v[2] != 2 || lat_v[3] != 2) begin
            errors++;
            $display("FAIL latency4 got %0d/%0d expected 2/2", lat_v[2], lat_v[3]);
        end
    endtask

    task automatic test_start_held();
        @(posedge clk); #1;
        a_in = 16'h1234;
        b_in = 16'h1235;
        start_v = 4'b0001;
        push_exp(0, 3'b001);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            a_in = 16'hFFFF - 16'(k);
            b_in = 16'h0000 + 16'(k);
            @(posedge clk); #1;
        end
        start_v = '0;
        checks++;
        if (done_v[0] !== 1'b1 || {gt_v[0], eq_v[0], lt_v[0]} !== 3'b001) begin
            errors++;
            $display("FAIL start_held got done=%b gel=%b expected done=1 gel=001", done_v[0], {gt_v[0], eq_v[0], lt_v[0]});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_held_idle got done=%b busy=%b expected 0/0", done_v[0], busy_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk); #1;
        a_in = 16'h0001;
        b_in = 16'h0002;
        start_v = 4'b0001;
        push_exp(0, 3'b001);
        @(posedge clk); #1;
        start_v = '0;
        n = 0;
        while (done_v[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_timeout got done=%b expected 1", done_v[0]);
        end
        a_in = 16'h9999;
        b_in = 16'h1111;
        start_v = 4'b0001;
        push_exp(0, 3'b100);
        @(posedge clk); #1;
        start_v = '0;
        @(negedge clk);
        n = 1;
        checks++;
        if ({gt_v[0], eq_v[0], lt_v[0]} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_hold_old got %b expected 001", {gt_v[0], eq_v[0], lt_v[0]});
        end
        while (done_v[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4 || {gt_v[0], eq_v[0], lt_v[0]} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_spacing got %0d cycles gel=%b expected 4 cycles gel=100", n, {gt_v[0], eq_v[0], lt_v[0]});
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(posedge clk); #1;
        a_in = 16'h1234;
        b_in = 16'h1235;
        start_v = 4'b0001;
        @(posedge clk); #1;
        start_v = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || {gt_v[0], eq_v[0], lt_v[0]} !== 3'b000) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b gel=%b expected 0 0 000",
                     busy_v[0], done_v[0], {gt_v[0], eq_v[0], lt_v[0]});
        end
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midrun_no_done got %0d pulses expected 0", dones);
        end
        run_cmp(4'b0001, 16'h0F0F, 16'h0F0F);
        checks++;
        if ({gt_v[0], eq_v[0], lt_v[0]} !== 3'b010) begin
            errors++;
            $display("FAIL after_reset got %b expected 010", {gt_v[0], eq_v[0], lt_v[0]});
        end
    endtask

    task automatic test_random();
        logic [15:0] av, bv;
        for (int k = 0; k < 260; k++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: bv = av;
                1: bv = av ^ (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            run_cmp(4'hF, av, bv);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_equal();
        test_width4();
        test_start_held();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (q_size(0) + q_size(1) + q_size(2) + q_size(3) != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending expected 0",
                     q_size(0) + q_size(1) + q_size(2) + q_size(3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
